// File: rtl/spectrum_bin_writer.sv
`default_nettype none
// ============================================================================
// Module   : spectrum_bin_writer
// Purpose  : Folds a 256-point FFT magnitude stream into 16 peak-held bins,
//            double-buffered so the display only updates on VGA vsync.
// Revision : 1.0  initial release
// ============================================================================
module spectrum_bin_writer #(
    parameter int NUM_BINS    = 16,
    parameter int PTS_PER_BIN = 16,
    parameter int MAG_W       = 16,
    parameter int OUT_W       = 12,
    parameter int DECAY_SHIFT = 3
) (
    input  logic                      clk_50MHz,
    input  logic                      rst,
    input  logic                      mag_valid,
    output logic                      mag_ready,
    input  logic [MAG_W-1:0]          mag,
    input  logic                      mag_last,
    input  logic                      vga_vsync,
    output logic [NUM_BINS*OUT_W-1:0] bin_amplitudes,
    output logic                      frame_err,
    output logic                      dropped
);

    // Bin/offset split of the sample index relies on power-of-two sizes.
    localparam int c_IDX_W = $clog2(NUM_BINS * PTS_PER_BIN);
    localparam int c_BIN_W = $clog2(NUM_BINS);
    localparam int c_PPB_W = $clog2(PTS_PER_BIN);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_BINS * PTS_PER_BIN - 1);
    localparam logic [c_BIN_W-1:0] c_LAST_BIN = c_BIN_W'(NUM_BINS - 1);

    typedef enum logic [0:0] {
        S_ACCUM   = 1'b0,
        S_PUBLISH = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_IDX_W-1:0]   r_idx;
    logic [c_BIN_W-1:0]   r_pub_idx;
    logic [OUT_W-1:0]     r_new  [NUM_BINS];
    logic [OUT_W-1:0]     r_pend [NUM_BINS];
    logic [OUT_W-1:0]     r_disp [NUM_BINS];
    logic                 r_pend_valid;
    logic                 r_frame_err;
    logic                 r_dropped;
    logic                 r_vs_meta;
    logic                 r_vs_sync;
    logic                 r_vs_prev;

    logic                 w_accept;
    logic                 w_at_last;
    logic                 w_frame_end;
    logic                 w_pub_done;
    logic                 w_vs_fall;
    logic                 w_copy;
    logic [c_BIN_W-1:0]   w_bin;
    logic                 w_first;
    logic [OUT_W-1:0]     w_sat;
    logic [OUT_W-1:0]     w_acc_val;
    logic [OUT_W-1:0]     w_decayed;
    logic [OUT_W-1:0]     w_pub_val;

    assign mag_ready   = (r_state == S_ACCUM);
    assign w_accept    = mag_valid & mag_ready;
    assign w_at_last   = (r_idx == c_LAST_IDX);
    assign w_frame_end = w_accept & (mag_last | w_at_last);
    assign w_pub_done  = (r_state == S_PUBLISH) && (r_pub_idx == c_LAST_BIN);
    assign w_vs_fall   = r_vs_prev & ~r_vs_sync;
    assign w_copy      = w_vs_fall & r_pend_valid;
    assign w_bin       = r_idx[c_IDX_W-1:c_PPB_W];
    assign w_first     = (r_idx[c_PPB_W-1:0] == '0);

    always_comb begin
        w_sat     = (|mag[MAG_W-1:OUT_W]) ? {OUT_W{1'b1}} : mag[OUT_W-1:0];
        w_acc_val = w_sat;
        if (!w_first && (r_new[w_bin] > w_sat)) begin
            w_acc_val = r_new[w_bin];
        end
        w_decayed = r_pend[r_pub_idx] - (r_pend[r_pub_idx] >> DECAY_SHIFT);
        w_pub_val = (r_new[r_pub_idx] > w_decayed) ? r_new[r_pub_idx] : w_decayed;
    end

    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            r_state <= S_ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_ACCUM:   if (w_frame_end) w_state_nxt = S_PUBLISH;
            S_PUBLISH: if (w_pub_done)  w_state_nxt = S_ACCUM;
            default:   w_state_nxt = S_ACCUM;
        endcase
    end

    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            // Vsync idles high; presetting the chain avoids a false edge out of reset.
            r_vs_meta    <= 1'b1;
            r_vs_sync    <= 1'b1;
            r_vs_prev    <= 1'b1;
            r_idx        <= '0;
            r_pub_idx    <= '0;
            r_pend_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_dropped    <= 1'b0;
            for (int i = 0; i < NUM_BINS; i++) begin
                r_new[i]  <= '0;
                r_pend[i] <= '0;
                r_disp[i] <= '0;
            end
        end else begin
            r_vs_meta <= vga_vsync;
            r_vs_sync <= r_vs_meta;
            r_vs_prev <= r_vs_sync;
            // A copy in the frame-end cycle consumes pending, so no drop is reported.
            r_dropped <= w_frame_end & r_pend_valid & ~w_vs_fall;

            if (w_copy) begin
                for (int i = 0; i < NUM_BINS; i++) begin
                    r_disp[i] <= r_pend[i];
                end
            end

            if (w_pub_done) begin
                r_pend_valid <= 1'b1;
            end else if (w_frame_end || w_copy) begin
                r_pend_valid <= 1'b0;
            end

            if (w_frame_end && (mag_last != w_at_last)) begin
                r_frame_err <= 1'b1;
            end

            if (w_accept) begin
                r_new[w_bin] <= w_acc_val;
                r_idx        <= w_frame_end ? '0 : r_idx + 1'b1;
            end

            if (r_state == S_PUBLISH) begin
                r_pend[r_pub_idx] <= w_pub_val;
                r_new[r_pub_idx]  <= '0;
                r_pub_idx         <= w_pub_done ? '0 : r_pub_idx + 1'b1;
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_BINS; g++) begin : g_out
            assign bin_amplitudes[g*OUT_W +: OUT_W] = r_disp[g];
        end
    endgenerate

    assign frame_err = r_frame_err;
    assign dropped   = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_spectrum_bin_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_spectrum_bin_writer
// Purpose  : Directed self-checking bench for spectrum_bin_writer.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_spectrum_bin_writer;

    localparam int c_NB = 16;
    localparam int c_OW = 12;

    logic                 clk_50MHz = 1'b0;
    logic                 rst       = 1'b1;
    logic                 mag_valid = 1'b0;
    logic                 mag_ready;
    logic [15:0]          mag       = '0;
    logic                 mag_last  = 1'b0;
    logic                 vga_vsync = 1'b1;
    logic [c_NB*c_OW-1:0] bin_amplitudes;
    logic                 frame_err;
    logic                 dropped;

    int vectors = 0;
    int errors  = 0;
    int drop_cnt = 0;

    spectrum_bin_writer dut (
        .clk_50MHz      (clk_50MHz),
        .rst            (rst),
        .mag_valid      (mag_valid),
        .mag_ready      (mag_ready),
        .mag            (mag),
        .mag_last       (mag_last),
        .vga_vsync      (vga_vsync),
        .bin_amplitudes (bin_amplitudes),
        .frame_err      (frame_err),
        .dropped        (dropped)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    always @(negedge clk_50MHz) if (dropped === 1'b1) drop_cnt++;

    function automatic logic [c_OW-1:0] get_bin(input int i);
        return bin_amplitudes[i*c_OW +: c_OW];
    endfunction

    task automatic do_reset();
        @(negedge clk_50MHz);
        rst = 1'b1; mag_valid = 1'b0; mag_last = 1'b0; vga_vsync = 1'b1;
        repeat (2) @(negedge clk_50MHz);
        rst = 1'b0;
        @(negedge clk_50MHz);
    endtask

    // Sends n samples (last one flagged), value fill except index sp_idx.
    task automatic send_frame(input int n, input logic [15:0] fill,
                              input int sp_idx, input logic [15:0] sp_val);
        for (int k = 0; k < n; k++) begin
            @(negedge clk_50MHz);
            mag_valid = 1'b1;
            mag       = (k == sp_idx) ? sp_val : fill;
            mag_last  = (k == n - 1);
            for (int g = 0; g < 100 && !mag_ready; g++) @(negedge clk_50MHz);
            @(posedge clk_50MHz);
            #1;
            mag_valid = 1'b0;
            mag_last  = 1'b0;
        end
    endtask

    // Counts cycles with mag_ready low after a frame; gives up at 200.
    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (cycles < 200) begin
            @(negedge clk_50MHz);
            if (mag_ready) break;
            cycles++;
        end
    endtask

    task automatic pulse_vsync(input int low_cycles);
        @(negedge clk_50MHz);
        vga_vsync = 1'b0;
        repeat (low_cycles) @(negedge clk_50MHz);
        vga_vsync = 1'b1;
        repeat (4) @(negedge clk_50MHz);
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < c_NB; i++) begin
            vectors++;
            if (get_bin(i) !== 12'd0) begin
                errors++;
                $display("FAIL reset_bin%0d: got %0d want 0", i, get_bin(i));
            end
        end
        vectors++;
        if ({mag_ready, frame_err, dropped} !== 3'b100) begin
            errors++;
            $display("FAIL reset_flags: ready/err/drop got %b want 100",
                     {mag_ready, frame_err, dropped});
        end
    endtask

    task automatic test_basic();
        int cyc;
        do_reset();
        send_frame(256, 16'd100, -1, 16'd0);
        wait_ready(cyc);
        vectors++;
        if (cyc !== 16) begin
            errors++;
            $display("FAIL basic_ready_low: got %0d cycles want 16", cyc);
        end
        vectors++;
        if (get_bin(0) !== 12'd0) begin
            errors++;
            $display("FAIL basic_before_vsync: bin0 got %0d want 0", get_bin(0));
        end
        pulse_vsync(6);
        for (int i = 0; i < c_NB; i++) begin
            vectors++;
            if (get_bin(i) !== 12'd100) begin
                errors++;
                $display("FAIL basic_bin%0d: got %0d want 100", i, get_bin(i));
            end
        end
        vectors++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL basic_frame_err: got %b want 0", frame_err);
        end
    endtask

    task automatic test_saturate();
        int cyc;
        do_reset();
        send_frame(256, 16'd5, 37, 16'h2000);
        wait_ready(cyc);
        pulse_vsync(6);
        for (int i = 0; i < c_NB; i++) begin
            vectors++;
            if (get_bin(i) !== ((i == 2) ? 12'd4095 : 12'd5)) begin
                errors++;
                $display("FAIL sat_bin%0d: got %0d want %0d", i, get_bin(i),
                         (i == 2) ? 4095 : 5);
            end
        end
    endtask

    task automatic test_decay();
        int cyc;
        logic [11:0] exp_v [3];
        logic [15:0] fill  [3];
        exp_v[0] = 12'd800; exp_v[1] = 12'd700; exp_v[2] = 12'd613;
        fill[0]  = 16'd800; fill[1]  = 16'd0;   fill[2]  = 16'd0;
        do_reset();
        for (int f = 0; f < 3; f++) begin
            send_frame(256, fill[f], -1, 16'd0);
            wait_ready(cyc);
            pulse_vsync(6);
            vectors++;
            if (get_bin(0) !== exp_v[f] || get_bin(15) !== exp_v[f]) begin
                errors++;
                $display("FAIL decay_frame%0d: bins0/15 got %0d/%0d want %0d",
                         f, get_bin(0), get_bin(15), exp_v[f]);
            end
        end
    endtask

    task automatic test_dropped();
        int cyc;
        do_reset();
        drop_cnt = 0;
        send_frame(256, 16'd500, -1, 16'd0);
        wait_ready(cyc);
        send_frame(256, 16'd200, -1, 16'd0);
        wait_ready(cyc);
        vectors++;
        if (drop_cnt !== 1) begin
            errors++;
            $display("FAIL dropped_pulses: got %0d want 1", drop_cnt);
        end
        pulse_vsync(6);
        vectors++;
        if (get_bin(7) !== 12'd438) begin
            errors++;
            $display("FAIL dropped_value: bin7 got %0d want 438", get_bin(7));
        end
    endtask

    task automatic test_short_frame();
        int cyc;
        do_reset();
        send_frame(256, 16'd400, -1, 16'd0);
        wait_ready(cyc);
        pulse_vsync(6);
        send_frame(64, 16'd1000, -1, 16'd0);
        wait_ready(cyc);
        vectors++;
        if (cyc !== 16) begin
            errors++;
            $display("FAIL short_ready_low: got %0d cycles want 16", cyc);
        end
        vectors++;
        if (frame_err !== 1'b1) begin
            errors++;
            $display("FAIL short_frame_err: got %b want 1", frame_err);
        end
        pulse_vsync(6);
        for (int i = 0; i < c_NB; i++) begin
            vectors++;
            if (get_bin(i) !== ((i < 4) ? 12'd1000 : 12'd350)) begin
                errors++;
                $display("FAIL short_bin%0d: got %0d want %0d", i, get_bin(i),
                         (i < 4) ? 1000 : 350);
            end
        end
        // Next frame must start at index 0: sample 0 lands in bin 0.
        send_frame(256, 16'd10, 0, 16'd900);
        wait_ready(cyc);
        pulse_vsync(6);
        vectors++;
        if (get_bin(0) !== 12'd900 || get_bin(4) !== 12'd307) begin
            errors++;
            $display("FAIL short_restart: bins0/4 got %0d/%0d want 900/307",
                     get_bin(0), get_bin(4));
        end
        vectors++;
        if (frame_err !== 1'b1) begin
            errors++;
            $display("FAIL short_err_sticky: got %b want 1", frame_err);
        end
    endtask

    task automatic test_vsync_in_publish();
        int cyc;
        do_reset();
        send_frame(256, 16'd300, -1, 16'd0);
        wait_ready(cyc);
        pulse_vsync(6);
        send_frame(256, 16'd600, -1, 16'd0);
        pulse_vsync(3);
        wait_ready(cyc);
        repeat (4) @(negedge clk_50MHz);
        vectors++;
        if (get_bin(0) !== 12'd300 || get_bin(15) !== 12'd300) begin
            errors++;
            $display("FAIL publish_hold: bins0/15 got %0d/%0d want 300",
                     get_bin(0), get_bin(15));
        end
        pulse_vsync(6);
        vectors++;
        if (get_bin(0) !== 12'd600 || get_bin(15) !== 12'd600) begin
            errors++;
            $display("FAIL publish_next: bins0/15 got %0d/%0d want 600",
                     get_bin(0), get_bin(15));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_decay();
        test_dropped();
        test_short_frame();
        test_vsync_in_publish();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spectrum_bin_writer.md
Name: spectrum_bin_writer

Overview:
- Producer side of the 16-bin amplitude interface consumed by the VGA histogram renderer.
- Reduces a 256-point FFT magnitude stream to 16 bins by per-bin maximum, applies peak-hold decay, and saturates each bin to 12 bits.
- Bins are double-buffered: the visible `bin_amplitudes` array changes only at VGA vertical sync. This removes screen tearing from mid-frame updates.

Parameters:
- NUM_BINS, 16, number of output bins.
- PTS_PER_BIN, 16, FFT points folded into each bin. Frame length is NUM_BINS*PTS_PER_BIN = 256.
- MAG_W, 16, input magnitude width.
- OUT_W, 12, bin amplitude width.
- DECAY_SHIFT, 3, peak-hold decay: held value loses held>>DECAY_SHIFT per published frame.

Ports:
- clk_50MHz  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- mag_valid  input  1  magnitude sample valid.
- mag_ready  output  1  block can accept a sample.
- mag  input  MAG_W  FFT magnitude, in index order 0..255.
- mag_last  input  1  marks the final sample of an FFT frame.
- vga_vsync  input  1  VGA vsync, active-low, from the 25 MHz VGA domain. It is asynchronous to clk_50MHz.
- bin_amplitudes  output  OUT_W x NUM_BINS  displayed bin values, index 0 = lowest frequency.
- frame_err  output  1  sticky flag: frame length mismatch.
- dropped  output  1  single-cycle pulse when an unshown pending frame is overwritten.

Behaviour:
- Reset (asynchronous, immediate):
  - bin_amplitudes, the pending buffer and the new-frame buffer are all 0.
  - frame_err = 0, dropped = 0.
  - State = ACCUM, sample index = 0, mag_ready = 1.
- Handshake:
  - A sample is accepted only when mag_valid && mag_ready.
  - mag, mag_valid and mag_last may change freely while mag_ready = 0.
- Saturation: sat(mag) = all-ones (4095) if mag[MAG_W-1:OUT_W] != 0, otherwise mag[OUT_W-1:0].
- ACCUM state:
  - Each accepted sample at index k updates new[k/PTS_PER_BIN] = max(new[...], sat(mag)), then increments k.
  - The first sample of each bin replaces the bin value; it is not max'd with stale data.
  - The frame ends on an accepted sample with mag_last = 1 OR k = 255.
  - mag_last at k != 255: set frame_err. Bins not reached in this frame are treated as new = 0.
  - k = 255 without mag_last: set frame_err, and the frame still ends. The next accepted sample is index 0 of a new frame.
  - At frame end: go to PUBLISH, mag_ready = 0, pending_valid = 0.
- PUBLISH state:
  - Takes 16 cycles, one bin per cycle, i = 0..15.
  - decayed = pending[i] - (pending[i] >> DECAY_SHIFT).
  - pending[i] = max(new[i], decayed).
  - new[i] is cleared to 0.
  - After bin 15: pending_valid = 1, k = 0, return to ACCUM with mag_ready = 1.
- Latency: last sample accepted at cycle N. PUBLISH runs N+1..N+16. pending_valid and mag_ready are high from N+17.
- Vsync crossing:
  - vga_vsync passes through a 2-flop synchronizer into clk_50MHz.
  - A falling edge is detected on the synchronized signal.
  - If the edge occurs and pending_valid = 1: copy all 16 pending bins to bin_amplitudes in one cycle, then clear pending_valid.
  - If the edge occurs during PUBLISH (pending_valid = 0): no copy, and bin_amplitudes is held.
- Dropped frames: entering PUBLISH while pending_valid = 1 pulses dropped for 1 cycle. The newer frame replaces the older one.
- Simultaneous events:
  - A vsync edge and frame end in the same cycle: the copy uses the old pending values and completes first, then PUBLISH starts.
  - In this case dropped is not pulsed, because pending was consumed.
- Reset mid-PUBLISH: all buffers return to 0 and there is no partial copy.
- frame_err clears only on rst.

Test Plan:
- Reset, then one frame with mag = 100 for all 256 samples and mag_last on sample 255, then a vsync falling edge → all bin_amplitudes = 100. mag_ready is 0 for exactly 16 cycles after the last sample.
- Frame with sample index 37 = 0x2000 and all others 5 → bin 2 = 4095 (saturated), other bins = 5.
- Frame 1 all 800, frame 2 all 0, vsync after each → 800, then 700 (800 - 800>>3). A third frame of all 0 → 613.
- Two complete frames (500 then 200) with no vsync between → dropped pulses once. The next vsync shows max(200, 500 - 62) = 438.
- mag_last on sample 63 → frame_err = 1. Bins 0-3 get the data values, bins 4-15 get decayed old values. The next sample is index 0.
- Vsync falling edge during PUBLISH → bin_amplitudes unchanged. The next vsync edge after PUBLISH completes shows the new values.
